// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one uart_tx byte transmitter
// among N requesters, with an optional per-requester lock that keeps the
// grant across a multi-byte message.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   req_vld      [N]    requester i has a byte ready
//   req_data     [8N]   byte of requester i in bits [8i+7:8i]
//   req_lock     [N]    requester i keeps the grant after the current byte
//   req_rdy      [N]    one-cycle accept pulse to the granted requester
//   tx_din       [8]    byte to uart_tx, stable for the whole frame
//   tx_din_vld          one-cycle start pulse to uart_tx
//   busy                uart_tx busy flag
//   grant_id     [IDW]  current or last granted requester
//   grant_act           a grant is held (frame in progress or locked)
//   err_to              sticky flag: busy never rose after a start pulse
module uart_tx_arb #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int BUSY_TO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_vld,
  input  logic [8*N-1:0]   req_data,
  input  logic [N-1:0]     req_lock,
  output logic [N-1:0]     req_rdy,
  output logic [7:0]       tx_din,
  output logic             tx_din_vld,
  input  logic             busy,
  output logic [IDW-1:0]   grant_id,
  output logic             grant_act,
  output logic             err_to
);

  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(BUSY_TO + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_WAIT_HI = 3'd2;
  localparam logic [2:0] ST_WAIT_LO = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]     state, state_nxt;
  logic [N-1:0]   req_rdy_nxt;
  logic [7:0]     tx_din_nxt;
  logic           tx_din_vld_nxt;
  logic [IDW-1:0] grant_id_nxt;
  logic           grant_act_nxt;
  logic           err_to_nxt;
  logic           lock_hold, lock_hold_nxt;
  logic [CW-1:0]  to_cnt, to_cnt_nxt;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [7:0]     win_byte;

  // Winner search: locked owner only, else first valid after the last grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = grant_id;
    if (lock_hold) begin
      win_found = req_vld[SW'(grant_id)];
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (!win_found && req_vld[SW'((int'(grant_id) + k) % N)]) begin
          win_found = 1'b1;
          win_idx   = IDW'((int'(grant_id) + k) % N);
        end
      end
    end
  end

  // Byte of the selected requester.
  always_comb begin
    win_byte = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (IDW'(i) == win_idx) win_byte = req_data[8*i +: 8];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt      = state;
    req_rdy_nxt    = '0;
    tx_din_nxt     = tx_din;
    tx_din_vld_nxt = 1'b0;
    grant_id_nxt   = grant_id;
    err_to_nxt     = err_to;
    lock_hold_nxt  = lock_hold;
    to_cnt_nxt     = to_cnt;

    case (state)
      ST_IDLE: begin
        // An external user holding busy defers arbitration entirely.
        if (!busy && win_found) begin
          grant_id_nxt = win_idx;
          tx_din_nxt   = win_byte;
          req_rdy_nxt  = N'(1) << win_idx;
          state_nxt    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tx_din_vld_nxt = 1'b1;
        to_cnt_nxt     = '0;
        state_nxt      = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (busy) begin
          state_nxt = ST_WAIT_LO;
        end else if (to_cnt == CW'(BUSY_TO - 1)) begin
          err_to_nxt = 1'b1;
          state_nxt  = ST_DONE;
        end else begin
          to_cnt_nxt = to_cnt + CW'(1);
        end
      end
      ST_WAIT_LO: begin
        if (!busy) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // Lock is re-sampled after every byte so a message ends cleanly.
        lock_hold_nxt = req_lock[SW'(grant_id)];
        state_nxt     = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    grant_act_nxt = (state_nxt != ST_IDLE) || lock_hold_nxt;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_rdy    <= '0;
      tx_din     <= 8'h00;
      tx_din_vld <= 1'b0;
      grant_id   <= IDW'(N - 1);
      grant_act  <= 1'b0;
      err_to     <= 1'b0;
      lock_hold  <= 1'b0;
      to_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      req_rdy    <= req_rdy_nxt;
      tx_din     <= tx_din_nxt;
      tx_din_vld <= tx_din_vld_nxt;
      grant_id   <= grant_id_nxt;
      grant_act  <= grant_act_nxt;
      err_to     <= err_to_nxt;
      lock_hold  <= lock_hold_nxt;
      to_cnt     <= to_cnt_nxt;
    end
  end

endmodule
